// File: rtl/sobel_window_buffer_pkg.sv
// Shared types and constants for the gray/Sobel window buffer slice.
package sobel_window_buffer_pkg;

    localparam int MAX_PIXEL_BITS = 8;
    localparam int DEF_IMG_WIDTH  = 8;
    localparam int DEF_IMG_HEIGHT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } win_state_t;

    typedef logic [MAX_PIXEL_BITS-1:0] pixel_t;

    function automatic logic is_active(input win_state_t state);
        return (state == FILL) || (state == STREAM);
    endfunction

endpackage

// File: rtl/sobel_window_buffer_line_delay.sv
// Fixed-length shift register used as a one-line pixel delay.
module sobel_window_buffer_line_delay #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Shift one entry per enabled cycle; oldest entry falls out of the far end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (shift_en) begin
            mem_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/sobel_window_buffer.sv
// Turns a raster gray-pixel stream into 3x3 neighbourhood windows for the Sobel kernel.
module sobel_window_buffer
    import sobel_window_buffer_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0]   in_pixel_i,
    output logic [9*MAX_PIXEL_BITS-1:0] window_o,
    output logic                        window_vld_o,
    output logic                        frame_done_o,
    output logic                        busy_o
);

    localparam int B     = MAX_PIXEL_BITS;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    win_state_t       state_r;
    win_state_t       state_next_s;
    logic [COL_W-1:0] col_cnt_r;
    logic [ROW_W-1:0] row_cnt_r;

    logic             accept_s;
    logic             last_in_row_s;
    logic             last_in_frame_s;
    logic             interior_s;
    logic             busy_next_s;
    logic             frame_done_next_s;

    pixel_t           lb0_out_s;
    pixel_t           lb1_out_s;
    // Columns c-2 (index 1) and c-1 (index 0); column c is the live tap of each row.
    pixel_t           top_r [2];
    pixel_t           mid_r [2];
    pixel_t           bot_r [2];

    logic [9*B-1:0]   window_next_s;
    logic [9*B-1:0]   window_r;
    logic             window_vld_r;
    logic             frame_done_r;
    logic             busy_r;

    // Acceptance qualifiers and position decodes for the pixel on the bus.
    always_comb begin
        accept_s        = px_rdy_i && is_active(state_r) && !start_i;
        last_in_row_s   = (col_cnt_r == COL_LAST);
        last_in_frame_s = last_in_row_s && (row_cnt_r == ROW_LAST);
        interior_s      = (row_cnt_r >= ROW_TWO) && (col_cnt_r >= COL_TWO);
    end

    // Frame state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a start pulse always restarts the frame in FILL.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (start_i) begin
                    state_next_s = FILL;
                end else if (accept_s && last_in_row_s && (row_cnt_r == ROW_ONE)) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = FILL;
                end
            end
            STREAM: begin
                if (start_i) begin
                    state_next_s = FILL;
                end else if (accept_s && last_in_frame_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = STREAM;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the next state so they can be registered.
    always_comb begin
        busy_next_s       = is_active(state_next_s);
        frame_done_next_s = (state_next_s == DONE);
    end

    // Registered status outputs, aligned with the state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            busy_r       <= busy_next_s;
            frame_done_r <= frame_done_next_s;
        end
    end

    // Raster position counters with explicit wrap.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_cnt_r <= '0;
            row_cnt_r <= '0;
        end else if (start_i) begin
            col_cnt_r <= '0;
            row_cnt_r <= '0;
        end else if (accept_s) begin
            if (last_in_row_s) begin
                col_cnt_r <= '0;
                if (row_cnt_r == ROW_LAST) begin
                    row_cnt_r <= '0;
                end else begin
                    row_cnt_r <= row_cnt_r + ROW_W'(1);
                end
            end else begin
                col_cnt_r <= col_cnt_r + COL_ONE;
            end
        end
    end

    sobel_window_buffer_line_delay #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (B)
    ) u_lb1 (
        .clk      (clk_i),
        .rst      (reset_i),
        .shift_en (accept_s),
        .din      (in_pixel_i),
        .dout     (lb1_out_s)
    );

    sobel_window_buffer_line_delay #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (B)
    ) u_lb0 (
        .clk      (clk_i),
        .rst      (reset_i),
        .shift_en (accept_s),
        .din      (lb1_out_s),
        .dout     (lb0_out_s)
    );

    // Column history for the three window rows.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                top_r[i] <= '0;
                mid_r[i] <= '0;
                bot_r[i] <= '0;
            end
        end else if (accept_s) begin
            top_r[1] <= top_r[0];
            mid_r[1] <= mid_r[0];
            bot_r[1] <= bot_r[0];
            top_r[0] <= lb0_out_s;
            mid_r[0] <= lb1_out_s;
            bot_r[0] <= in_pixel_i;
        end
    end

    // Assemble the window; w[0] is top-left, w[8] is the incoming pixel.
    always_comb begin
        window_next_s          = '0;
        window_next_s[0*B +: B] = top_r[1];
        window_next_s[1*B +: B] = top_r[0];
        window_next_s[2*B +: B] = lb0_out_s;
        window_next_s[3*B +: B] = mid_r[1];
        window_next_s[4*B +: B] = mid_r[0];
        window_next_s[5*B +: B] = lb1_out_s;
        window_next_s[6*B +: B] = bot_r[1];
        window_next_s[7*B +: B] = bot_r[0];
        window_next_s[8*B +: B] = in_pixel_i;
    end

    // Window register holds until the next interior pixel is accepted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            window_r     <= '0;
            window_vld_r <= 1'b0;
        end else begin
            window_vld_r <= accept_s && interior_s;
            if (accept_s && interior_s) begin
                window_r <= window_next_s;
            end
        end
    end

    assign window_o     = window_r;
    assign window_vld_o = window_vld_r;
    assign frame_done_o = frame_done_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed scoreboard bench for sobel_window_buffer on a 4x4 ramp image.
module tb_sobel_window_buffer;
    import sobel_window_buffer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int B  = MAX_PIXEL_BITS;
    localparam int WB = 9 * B;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          px_rdy_i = 1'b0;
    logic [B-1:0]  in_pixel_i = '0;
    logic [WB-1:0] window_o;
    logic          window_vld_o;
    logic          frame_done_o;
    logic          busy_o;

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 idle, 1 filling/streaming, 2 done.
    int m_state = 0;
    int m_row   = 0;
    int m_col   = 0;
    logic [B-1:0]  img [H][W];
    logic [WB-1:0] q [$];
    logic [WB-1:0] got [$];
    logic [WB-1:0] last_win = '0;

    always #5 clk = ~clk;

    sobel_window_buffer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .px_rdy_i     (px_rdy_i),
        .in_pixel_i   (in_pixel_i),
        .window_o     (window_o),
        .window_vld_o (window_vld_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] model_win(input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*B +: B] = img[r-2+k/3][c-2+k%3];
        end
        return w;
    endfunction

    function automatic logic [WB-1:0] ramp_win(input int r0, input int c0);
        logic [WB-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*B +: B] = B'((r0 + k/3) * W + c0 + k%3);
        end
        return w;
    endfunction

    task automatic tick(input logic s, input logic r, input logic [B-1:0] p);
        logic          acc;
        logic [WB-1:0] exp_w;
        start_i    = s;
        px_rdy_i   = r;
        in_pixel_i = p;
        acc = r && (m_state == 1) && !s;
        if (s) begin
            m_state = 1;
            m_row   = 0;
            m_col   = 0;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (acc) begin
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) q.push_back(model_win(m_row, m_col));
            if (m_row == H-1 && m_col == W-1) m_state = 2;
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        px_rdy_i = 1'b0;
        if (window_vld_o) begin
            chk("vld_expected", WB'(q.size() != 0), WB'(1));
            if (q.size() != 0) begin
                exp_w = q.pop_front();
                chk("window", window_o, exp_w);
                last_win = exp_w;
            end
            got.push_back(window_o);
        end else begin
            chk("window_missing", WB'(q.size()), WB'(0));
            q.delete();
            chk("window_hold", window_o, last_win);
        end
        chk("frame_done", WB'(frame_done_o), WB'(m_state == 2));
        chk("busy", WB'(busy_o), WB'(m_state == 1));
    endtask

    task automatic run_frame(input int maxgap, input int npix, input bit with_start);
        int g;
        if (with_start) tick(1'b1, 1'b0, '0);
        for (int i = 0; i < npix; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) tick(1'b0, 1'b0, '0);
            tick(1'b0, 1'b1, B'(i));
        end
        if (npix == W*H) begin
            tick(1'b0, 1'b0, '0);
            tick(1'b0, 1'b0, '0);
        end
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, WB'(got.size()), WB'(4));
        if (got.size() == 4) begin
            chk({tag, "_w0"}, got[0], ramp_win(0, 0));
            chk({tag, "_w1"}, got[1], ramp_win(0, 1));
            chk({tag, "_w2"}, got[2], ramp_win(1, 0));
            chk({tag, "_w3"}, got[3], ramp_win(1, 1));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_window", window_o, '0);
        chk("rst_vld", WB'(window_vld_o), '0);
        chk("rst_done", WB'(frame_done_o), '0);
        chk("rst_busy", WB'(busy_o), '0);
        reset_i = 1'b0;

        // Ramp frame, back-to-back strobes.
        got.delete();
        run_frame(0, 16, 1'b1);
        check_ramp("c1");

        // Same frame with random gaps.
        got.delete();
        run_frame(3, 16, 1'b1);
        check_ramp("c2");

        // Strobes in IDLE are ignored.
        got.delete();
        repeat (3) tick(1'b0, 1'b1, 8'd50);
        chk("c3_idle_windows", WB'(got.size()), WB'(0));
        run_frame(0, 16, 1'b1);
        check_ramp("c3");

        // Abort after pixel 9, then a full frame.
        got.delete();
        run_frame(0, 10, 1'b1);
        chk("c4_abort_windows", WB'(got.size()), WB'(0));
        got.delete();
        run_frame(0, 16, 1'b1);
        check_ramp("c4");

        // Start coincident with a strobe carrying pixel 99.
        got.delete();
        tick(1'b1, 1'b1, 8'd99);
        run_frame(0, 16, 1'b0);
        check_ramp("c5");

        // Asynchronous reset mid-frame after pixel 11.
        got.delete();
        run_frame(0, 12, 1'b1);
        chk("c6_pre_reset_window", window_o, ramp_win(0, 1));
        reset_i = 1'b1;
        #1;
        chk("c6_rst_window", window_o, '0);
        chk("c6_rst_vld", WB'(window_vld_o), '0);
        chk("c6_rst_done", WB'(frame_done_o), '0);
        chk("c6_rst_busy", WB'(busy_o), '0);
        m_state  = 0;
        m_row    = 0;
        m_col    = 0;
        last_win = '0;
        q.delete();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        tick(1'b0, 1'b1, 8'd77);
        got.delete();
        run_frame(0, 16, 1'b1);
        check_ramp("c6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
